// File: rtl/adc_sequencer.sv
// adc_sequencer: walks a fixed list of ADC channels, issues one conversion
// command at a time, averages 2^OSR_LOG2 matching responses per slot and
// presents each averaged result on a valid/ready output with sticky
// overrun and channel-mismatch flags.
module adc_sequencer #(
  parameter int          NUM_CH   = 4,
  parameter logic [39:0] CH_LIST  = 40'({5'd3, 5'd2, 5'd1, 5'd0}),
  parameter int          DATA_W   = 12,
  parameter int          OSR_LOG2 = 0
) (
  input  logic              clk_adc_clk,
  input  logic              reset_reset,
  input  logic              enable,
  output logic              cmd_valid,
  output logic [4:0]        cmd_channel,
  output logic              cmd_startofpacket,
  output logic              cmd_endofpacket,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [4:0]        rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              smp_valid,
  output logic [2:0]        smp_index,
  output logic [DATA_W-1:0] smp_data,
  input  logic              smp_ready,
  output logic              overrun,
  output logic              chan_err,
  input  logic              overrun_clr,
  input  logic              err_clr,
  output logic              busy
);

  // Accumulator has OSR_LOG2 headroom bits so a full set of samples cannot wrap.
  localparam int         ACC_W     = DATA_W + OSR_LOG2;
  localparam logic [4:0] LAST_CNT  = 5'((1 << OSR_LOG2) - 1);
  localparam logic [2:0] LAST_SLOT = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t            state;
  logic [2:0]        slot;
  logic [4:0]        cnt;
  logic [ACC_W-1:0]  acc;

  logic [4:0]        ch_tab [8];
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] result;
  logic [2:0]        slot_inc;
  logic [2:0]        slot_after;
  logic              match;
  logic              take;
  logic              load;
  logic              mismatch;

  // Unpack the channel list into one entry per slot; unused slots read 0.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tab
      assign ch_tab[gi] = CH_LIST[gi*5 +: 5];
    end
  endgenerate

  // Response qualification, averaging arithmetic and next-slot selection.
  always_comb begin
    sum        = acc + ACC_W'(rsp_data);
    result     = DATA_W'(sum >> OSR_LOG2);
    slot_inc   = (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
    match      = (rsp_channel == ch_tab[slot]);
    take       = (state == WAIT) && rsp_valid && match;
    mismatch   = (state == WAIT) && rsp_valid && !match;
    load       = take && (cnt == LAST_CNT);
    slot_after = load ? slot_inc : slot;
  end

  // Scan FSM with registered command/result outputs and sticky error flags.
  always_ff @(posedge clk_adc_clk) begin
    if (reset_reset) begin
      state             <= IDLE;
      slot              <= 3'd0;
      cnt               <= 5'd0;
      acc               <= '0;
      busy              <= 1'b0;
      cmd_valid         <= 1'b0;
      cmd_channel       <= 5'd0;
      cmd_startofpacket <= 1'b0;
      cmd_endofpacket   <= 1'b0;
      smp_valid         <= 1'b0;
      smp_index         <= 3'd0;
      smp_data          <= '0;
      overrun           <= 1'b0;
      chan_err          <= 1'b0;
    end else begin
      // A set event in the same cycle as a clear keeps the flag high.
      if (load && smp_valid && !smp_ready) overrun <= 1'b1;
      else if (overrun_clr)                overrun <= 1'b0;

      if (mismatch)     chan_err <= 1'b1;
      else if (err_clr) chan_err <= 1'b0;

      // A fresh result always overwrites the output register.
      if (load) begin
        smp_valid <= 1'b1;
        smp_data  <= result;
        smp_index <= slot;
      end else if (smp_valid && smp_ready) begin
        smp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          slot <= 3'd0;
          cnt  <= 5'd0;
          acc  <= '0;
          if (enable) begin
            state             <= CMD;
            busy              <= 1'b1;
            cmd_valid         <= 1'b1;
            cmd_channel       <= ch_tab[0];
            cmd_startofpacket <= 1'b1;
            cmd_endofpacket   <= (LAST_SLOT == 3'd0);
          end
        end
        CMD: begin
          // Command stays presented until accepted, regardless of enable.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            if (!match) begin
              // Reissue the same slot; channel/SOP/EOP registers still hold it.
              state     <= CMD;
              cmd_valid <= 1'b1;
            end else begin
              if (load) begin
                acc  <= '0;
                cnt  <= 5'd0;
                slot <= slot_inc;
              end else begin
                acc <= sum;
                cnt <= cnt + 5'd1;
              end
              if (enable) begin
                state             <= CMD;
                cmd_valid         <= 1'b1;
                cmd_channel       <= ch_tab[slot_after];
                cmd_startofpacket <= (slot_after == 3'd0);
                cmd_endofpacket   <= (slot_after == LAST_SLOT);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                slot  <= 3'd0;
                cnt   <= 5'd0;
                acc   <= '0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: table-driven scan vectors, hand
// sequences for backpressure/error/stop/reset corners, randomized traffic
// checked against an averaging model, plus a single-slot no-oversampling unit.
module tb_adc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main unit: 3 slots (ch 1,2,5), 4x averaging.
  logic        reset_reset, enable, cmd_valid, cmd_startofpacket, cmd_endofpacket, cmd_ready;
  logic [4:0]  cmd_channel, rsp_channel;
  logic        rsp_valid, smp_valid, smp_ready, overrun, chan_err, overrun_clr, err_clr, busy;
  logic [11:0] rsp_data, smp_data;
  logic [2:0]  smp_index;

  // Second unit: 1 slot (ch 0), no averaging.
  logic        s1_enable, s1_cmd_valid, s1_cmd_sop, s1_cmd_eop, s1_cmd_ready;
  logic [4:0]  s1_cmd_channel, s1_rsp_channel;
  logic        s1_rsp_valid, s1_smp_valid, s1_smp_ready, s1_overrun, s1_chan_err, s1_busy;
  logic [11:0] s1_rsp_data, s1_smp_data;
  logic [2:0]  s1_smp_index;

  adc_sequencer #(.NUM_CH(3), .CH_LIST(40'({5'd5, 5'd2, 5'd1})), .DATA_W(12), .OSR_LOG2(2)) u0 (
    .clk_adc_clk(clk), .reset_reset(reset_reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel),
    .cmd_startofpacket(cmd_startofpacket), .cmd_endofpacket(cmd_endofpacket),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .smp_valid(smp_valid), .smp_index(smp_index), .smp_data(smp_data), .smp_ready(smp_ready),
    .overrun(overrun), .chan_err(chan_err), .overrun_clr(overrun_clr), .err_clr(err_clr),
    .busy(busy));

  adc_sequencer #(.NUM_CH(1), .DATA_W(12), .OSR_LOG2(0)) u1 (
    .clk_adc_clk(clk), .reset_reset(reset_reset), .enable(s1_enable),
    .cmd_valid(s1_cmd_valid), .cmd_channel(s1_cmd_channel),
    .cmd_startofpacket(s1_cmd_sop), .cmd_endofpacket(s1_cmd_eop),
    .cmd_ready(s1_cmd_ready), .rsp_valid(s1_rsp_valid), .rsp_channel(s1_rsp_channel),
    .rsp_data(s1_rsp_data), .smp_valid(s1_smp_valid), .smp_index(s1_smp_index),
    .smp_data(s1_smp_data), .smp_ready(s1_smp_ready), .overrun(s1_overrun),
    .chan_err(s1_chan_err), .overrun_clr(1'b0), .err_clr(1'b0), .busy(s1_busy));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rch;   // channel the ADC answers with
    logic [11:0] data;  // response data
    logic [4:0]  ch;    // expected command channel
    logic        sop;
    logic        eop;
    logic        vld;   // expected smp_valid after the response
    logic [11:0] res;
    logic [2:0]  idx;
    logic        err;   // response is a channel mismatch
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rch, int data, int ch, int sop, int eop,
                              int vld, int res, int idx, int err);
    vec_t v;
    v.rch = 5'(rch); v.data = 12'(data); v.ch = 5'(ch);
    v.sop = 1'(sop); v.eop = 1'(eop); v.vld = 1'(vld);
    v.res = 12'(res); v.idx = 3'(idx); v.err = 1'(err);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 100) begin
      nc();
      n++;
    end
    if (cmd_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: cmd_valid=%b after %0d cycles, expected 1", cmd_valid, n);
    end
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    nc();
    cmd_ready = 1'b0;
  endtask

  task automatic respond(input logic [4:0] ch, input logic [11:0] data);
    rsp_valid   = 1'b1;
    rsp_channel = ch;
    rsp_data    = data;
    nc();
    rsp_valid   = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1; enable = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    rsp_channel = 5'd0; rsp_data = 12'd0; smp_ready = 1'b1;
    overrun_clr = 1'b0; err_clr = 1'b0;
    repeat (2) nc();
    reset_reset = 1'b0;
  endtask

  // One command/response exchange with enable held high.
  task automatic txn(input vec_t v, input int hold);
    wait_cmd();
    check("cmd_channel", cmd_channel, v.ch);
    check("cmd_sop", cmd_startofpacket, v.sop);
    check("cmd_eop", cmd_endofpacket, v.eop);
    repeat (hold) begin
      nc();
      check("hold_valid", cmd_valid, 1);
      check("hold_channel", cmd_channel, v.ch);
    end
    accept();
    check("cmd_drop", cmd_valid, 0);
    respond(v.rch, v.data);
    check("smp_valid", smp_valid, v.vld);
    if (v.vld) begin
      check("smp_data", smp_data, v.res);
      check("smp_index", smp_index, v.idx);
    end
    check("cmd_relaunch", cmd_valid, 1);
    if (v.err) begin
      check("chan_err_set", chan_err, 1);
      check("reissue_channel", cmd_channel, v.ch);
      err_clr = 1'b1;
      nc();
      err_clr = 1'b0;
      check("chan_err_clr", chan_err, 0);
    end else begin
      check("chan_err_quiet", chan_err, 0);
    end
    $display("txn cmd_ch=%0d rsp_ch=%0d data=%0d -> smp_valid=%0d smp_data=%0d smp_index=%0d chan_err=%0d",
             v.ch, v.rch, v.data, smp_valid, smp_data, smp_index, chan_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int chl[3] = '{1, 2, 5};
    int m_slot, m_acc, m_cnt;
    vec_t v;
    logic [11:0] d1;

    s1_enable = 1'b0; s1_cmd_ready = 1'b0; s1_rsp_valid = 1'b0;
    s1_rsp_channel = 5'd0; s1_rsp_data = 12'd0; s1_smp_ready = 1'b1;

    // Scan, wrap, and channel-error vectors from a fresh reset.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 100 + i, 1, 1, 0, i == 3, 101, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(2, 4095, 2, 0, 0, i == 3, 4095, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(5, 4095, 5, 0, 1, i == 3, 4095, 2, 0));
    tbl.push_back(mk(7, 55, 1, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4095, 1, 1, 0, i == 3, 4095, 0, 0));
    tbl.push_back(mk(2, 0, 2, 0, 0, 0, 0, 0, 0));

    // Reset state.
    do_reset();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_smp_valid", smp_valid, 0);
    check("rst_flags", {overrun, chan_err}, 0);
    check("rst_outputs", {cmd_channel, cmd_startofpacket, cmd_endofpacket, smp_index, smp_data}, 0);

    enable = 1'b1;
    foreach (tbl[i]) txn(tbl[i], 0);

    // Command backpressure and result overrun.
    do_reset();
    enable = 1'b1;
    smp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = mk(i < 4 ? 1 : 2, i < 4 ? 200 : 300, i < 4 ? 1 : 2, i < 4, 0,
             i >= 3, i < 7 ? 200 : 300, i < 7 ? 0 : 1, 0);
      txn(v, i == 0 ? 5 : 0);
      if (i == 3) check("overrun_early", overrun, 0);
    end
    check("overrun_set", overrun, 1);
    overrun_clr = 1'b1;
    nc();
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);
    check("smp_held", smp_valid, 1);
    check("smp_overwritten", smp_data, 300);
    smp_ready = 1'b1;
    nc();
    check("smp_consumed", smp_valid, 0);

    // Channel error while the clear is asserted.
    do_reset();
    enable = 1'b1;
    wait_cmd();
    accept();
    respond(5'd7, 12'd10);
    check("err_first", chan_err, 1);
    check("err_reissue", cmd_channel, 1);
    accept();
    err_clr = 1'b1;
    respond(5'd9, 12'd10);
    err_clr = 1'b0;
    check("err_set_wins", chan_err, 1);
    err_clr = 1'b1;
    nc();
    err_clr = 1'b0;
    check("err_cleared", chan_err, 0);
    $display("txn chan_err set-vs-clear sequence done");

    // Stop during WAIT: response still consumed, then idle, restart at slot 0.
    do_reset();
    enable = 1'b1;
    wait_cmd();
    accept();
    enable = 1'b0;
    respond(5'd1, 12'd999);
    check("stop_cmd_valid", cmd_valid, 0);
    check("stop_busy", busy, 0);
    nc();
    check("stop_idle", cmd_valid, 0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) txn(mk(1, i == 3 ? 40 : 0, 1, 1, 0, i == 3, 10, 0, 0), 0);

    // Reset while a command is pending, then a stale response.
    wait_cmd();
    accept();
    respond(5'd3, 12'd1);
    check("pre_reset_err", chan_err, 1);
    check("pre_reset_cmd", cmd_valid, 1);
    reset_reset = 1'b1;
    enable = 1'b0;
    nc();
    reset_reset = 1'b0;
    check("rst_cmd_drop", cmd_valid, 0);
    check("rst_busy_mid", busy, 0);
    check("rst_flags_mid", {overrun, chan_err, smp_valid}, 0);
    respond(5'd1, 12'd5);
    check("stale_rsp_err", chan_err, 0);
    check("stale_rsp_smp", smp_valid, 0);
    check("stale_rsp_busy", busy, 0);
    enable = 1'b1;
    wait_cmd();
    check("restart_channel", cmd_channel, 1);
    check("restart_sop", cmd_startofpacket, 1);
    $display("txn reset-in-CMD sequence done");

    // Randomized traffic against an averaging model.
    do_reset();
    enable = 1'b1;
    m_slot = 0; m_acc = 0; m_cnt = 0;
    for (int r = 0; r < 60; r++) begin
      v.ch   = 5'(chl[m_slot]);
      v.sop  = (m_slot == 0);
      v.eop  = (m_slot == 2);
      v.data = 12'($urandom_range(0, 4095));
      v.err  = ($urandom_range(0, 7) == 0);
      v.rch  = v.err ? (v.ch ^ 5'($urandom_range(1, 31))) : v.ch;
      v.vld  = 1'b0; v.res = 12'd0; v.idx = 3'd0;
      if (!v.err) begin
        m_acc += int'(v.data);
        m_cnt++;
        if (m_cnt == 4) begin
          v.vld  = 1'b1;
          v.res  = 12'(m_acc / 4);
          v.idx  = 3'(m_slot);
          m_acc  = 0;
          m_cnt  = 0;
          m_slot = (m_slot + 1) % 3;
        end
      end
      txn(v, $urandom_range(0, 2));
    end

    // Single slot, no averaging: every response is a result one cycle later.
    s1_enable = 1'b1;
    s1_cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (s1_cmd_valid !== 1'b1 && n < 100) begin
        nc();
        n++;
      end
      check("s1_cmd_valid", s1_cmd_valid, 1);
      check("s1_cmd_channel", s1_cmd_channel, 0);
      check("s1_sop_eop", {s1_cmd_sop, s1_cmd_eop}, 2'b11);
      nc();
      d1 = (k < 2) ? 12'hABC : 12'($urandom_range(0, 4095));
      s1_rsp_valid = 1'b1;
      s1_rsp_channel = 5'd0;
      s1_rsp_data = d1;
      nc();
      s1_rsp_valid = 1'b0;
      check("s1_smp_valid", s1_smp_valid, 1);
      check("s1_smp_data", s1_smp_data, d1);
      check("s1_smp_index", s1_smp_index, 0);
      $display("txn s1 data=%0d -> smp_valid=%0d smp_data=%0d", d1, s1_smp_valid, s1_smp_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
